// File: rtl/can_form_checker_pkg.sv
// ---------------------------------------------------------------------------
// can_form_checker_pkg
// Shared CAN constants for the form-error monitor: default field codes for
// every fixed-form field, the EOF / delimiter lengths, the default error
// counter width and the result type of the per-sample check decode.
// ---------------------------------------------------------------------------
package can_form_checker_pkg;

  localparam int CAN_FIELD_W = 5;
  localparam int CAN_EOF_LEN = 7;
  localparam int CAN_DELIM_LEN = 8;
  localparam int CAN_CNT_W = 8;

  localparam logic [CAN_FIELD_W-1:0] CAN_F_CRC_DELIM = 5'b10001;
  localparam logic [CAN_FIELD_W-1:0] CAN_F_ACK_DELIM = 5'b10010;
  localparam logic [CAN_FIELD_W-1:0] CAN_F_EOF       = 5'b00101;
  localparam logic [CAN_FIELD_W-1:0] CAN_F_ERR_DELIM = 5'b11000;
  localparam logic [CAN_FIELD_W-1:0] CAN_F_OVL_DELIM = 5'b11001;

  // Outcome of checking one sampled bit.
  typedef enum logic [1:0] {
    CHK_NONE       = 2'd0,
    CHK_FORM_ERROR = 2'd1,
    CHK_OVERLOAD   = 2'd2
  } chk_result_e;

endpackage

// File: rtl/can_field_pos_counter.sv
// ---------------------------------------------------------------------------
// can_field_pos_counter
// Tracks the bit position inside the current frame field. Position is 0 on
// the first sample of a field, increments on each further sample of the same
// field and saturates at i_pos_limit (field length - 1).
// Ports:
//   i_Clock, i_Reset  clock / synchronous active-high reset
//   i_Sample          sample-point strobe; only these cycles update state
//   i_field           field code of the current sample
//   i_pos_limit       saturation value for the current field
//   o_pos             position of the current sample (combinational)
// ---------------------------------------------------------------------------
module can_field_pos_counter #(
  parameter int FIELD_W = 5,
  parameter int POS_W   = 3
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Sample,
  input  logic [FIELD_W-1:0] i_field,
  input  logic [POS_W-1:0]   i_pos_limit,
  output logic [POS_W-1:0]   o_pos
);

  logic [FIELD_W-1:0] prev_field_reg;
  logic [POS_W-1:0]   pos_reg;
  logic [POS_W-1:0]   pos_next;
  // Marks that a field has been seen since reset, so the first sample after
  // reset is always position 0 even if its code equals the cleared register.
  logic               seen_reg;

  always_comb begin
    pos_next = '0;
    if (seen_reg && (i_field == prev_field_reg)) begin
      if (pos_reg >= i_pos_limit) begin
        pos_next = i_pos_limit;
      end else begin
        pos_next = pos_reg + POS_W'(1);
      end
    end
  end

  assign o_pos = pos_next;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      prev_field_reg <= '0;
      pos_reg        <= '0;
      seen_reg       <= 1'b0;
    end else if (i_Sample) begin
      prev_field_reg <= i_field;
      pos_reg        <= pos_next;
      seen_reg       <= 1'b1;
    end
  end

endmodule

// File: rtl/can_form_checker.sv
// ---------------------------------------------------------------------------
// can_form_checker
// CAN form-error monitor. At each sample point checks the fixed-form bits
// (CRC delimiter, ACK delimiter, EOF, error and overload delimiters) for a
// dominant level, applying the receiver last-EOF-bit overload rule.
// Ports:
//   i_Clock, i_Reset  clock / synchronous active-high reset
//   i_Sample          one-cycle strobe at the bit sample point
//   i_Data            sampled bus level (1 = recessive)
//   i_frame_field     field code, valid with i_Sample
//   i_Is_Receiver     node is receiver (last EOF bit -> overload instead)
//   i_Clear           clears sticky flag and error count
//   o_form_error      one-cycle pulse per detected form error
//   o_form_field      field code of the most recent error (held)
//   o_overload        one-cycle pulse: dominant last EOF bit as receiver
//   o_form_sticky     set on any error until i_Clear
//   o_error_count     saturating count of errors since reset/clear
// ---------------------------------------------------------------------------
module can_form_checker
  import can_form_checker_pkg::*;
#(
  parameter int                 FIELD_W     = CAN_FIELD_W,
  parameter logic [FIELD_W-1:0] F_CRC_DELIM = CAN_F_CRC_DELIM,
  parameter logic [FIELD_W-1:0] F_ACK_DELIM = CAN_F_ACK_DELIM,
  parameter logic [FIELD_W-1:0] F_EOF       = CAN_F_EOF,
  parameter logic [FIELD_W-1:0] F_ERR_DELIM = CAN_F_ERR_DELIM,
  parameter logic [FIELD_W-1:0] F_OVL_DELIM = CAN_F_OVL_DELIM,
  parameter int                 EOF_LEN     = CAN_EOF_LEN,
  parameter int                 DELIM_LEN   = CAN_DELIM_LEN,
  parameter int                 CNT_W       = CAN_CNT_W
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Sample,
  input  logic               i_Data,
  input  logic [FIELD_W-1:0] i_frame_field,
  input  logic               i_Is_Receiver,
  input  logic               i_Clear,
  output logic               o_form_error,
  output logic [FIELD_W-1:0] o_form_field,
  output logic               o_overload,
  output logic               o_form_sticky,
  output logic [CNT_W-1:0]   o_error_count
);

  localparam int POS_W = (DELIM_LEN > 1) ? $clog2(DELIM_LEN) : 1;
  localparam logic [POS_W-1:0] EOF_LAST   = POS_W'(EOF_LEN - 1);
  localparam logic [POS_W-1:0] DELIM_LAST = POS_W'(DELIM_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [POS_W-1:0]   pos;
  logic [POS_W-1:0]   pos_limit;
  chk_result_e        chk_result;
  logic               err_hit;

  logic               form_error_reg;
  logic               overload_reg;
  logic [FIELD_W-1:0] form_field_reg;
  logic               sticky_reg;
  logic               sticky_next;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;

  // EOF is shorter than the delimiters; all other fields simply use the
  // delimiter length as their saturation point (they are never checked).
  always_comb begin
    pos_limit = DELIM_LAST;
    if (i_frame_field == F_EOF) begin
      pos_limit = EOF_LAST;
    end
  end

  can_field_pos_counter #(
    .FIELD_W (FIELD_W),
    .POS_W   (POS_W)
  ) u_pos_counter (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Sample    (i_Sample),
    .i_field     (i_frame_field),
    .i_pos_limit (pos_limit),
    .o_pos       (pos)
  );

  // Check decode: a dominant level in any fixed-form bit is a form error,
  // except the last EOF bit seen by a receiver, which signals overload.
  // Saturated positions beyond the field length are still checked.
  always_comb begin
    chk_result = CHK_NONE;
    if (i_Sample && !i_Data) begin
      if ((i_frame_field == F_CRC_DELIM) || (i_frame_field == F_ACK_DELIM) ||
          (i_frame_field == F_ERR_DELIM) || (i_frame_field == F_OVL_DELIM)) begin
        chk_result = CHK_FORM_ERROR;
      end else if (i_frame_field == F_EOF) begin
        if (i_Is_Receiver && (pos >= EOF_LAST)) begin
          chk_result = CHK_OVERLOAD;
        end else begin
          chk_result = CHK_FORM_ERROR;
        end
      end
    end
  end

  assign err_hit = (chk_result == CHK_FORM_ERROR);

  // An error in the same cycle as i_Clear wins: the count restarts at 1.
  always_comb begin
    sticky_next = sticky_reg;
    count_next  = count_reg;
    if (err_hit) begin
      sticky_next = 1'b1;
      if (i_Clear) begin
        count_next = CNT_W'(1);
      end else if (count_reg != CNT_MAX) begin
        count_next = count_reg + CNT_W'(1);
      end
    end else if (i_Clear) begin
      sticky_next = 1'b0;
      count_next  = '0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      form_error_reg <= 1'b0;
      overload_reg   <= 1'b0;
      form_field_reg <= '0;
      sticky_reg     <= 1'b0;
      count_reg      <= '0;
    end else begin
      form_error_reg <= err_hit;
      overload_reg   <= (chk_result == CHK_OVERLOAD);
      if (err_hit) begin
        form_field_reg <= i_frame_field;
      end
      sticky_reg <= sticky_next;
      count_reg  <= count_next;
    end
  end

  assign o_form_error  = form_error_reg;
  assign o_overload    = overload_reg;
  assign o_form_field  = form_field_reg;
  assign o_form_sticky = sticky_reg;
  assign o_error_count = count_reg;

endmodule
